srl_tap_reader: RTL and testbench
=================================

Name: srl_tap_reader

Overview:
- Enable-gated shift-register delay line with a dynamically addressed read tap, a fill counter and a registered output.
- Sits directly downstream of the fixed-depth enable shift chain. It consumes that chain's per-cycle output word and provides a selectable delay of 1..DEPTH pushes.
- Storage has no reset, so synthesis must map it onto SRL primitives (SRLC32E/SRL16E) with zero FD* cells in the storage path. Only the control and output registers use flops.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 32, number of storage stages; must be ≥2.
- AW, $clog2(DEPTH), tap address width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  shift enable; pushes in_data when high.
- in_data  input  WIDTH  word pushed into stage 0.
- flush  input  1  synchronous clear of the fill count; storage contents untouched.
- tap_addr  input  AW  stage to read (0 = newest word).
- out_data  output  WIDTH  registered tap data.
- out_valid  output  1  registered; high when the tapped stage holds a word pushed since the last reset or flush.
- fill_level  output  AW+1  pushes since last reset/flush, saturating at DEPTH.
- full  output  1  fill_level == DEPTH.

Behaviour:
- Reset: asynchronous assert, synchronous release.
  - out_data = 0, out_valid = 0, fill_level = 0, full = 0.
  - Storage is never reset and is not cleared on reset deassert.
- Push (in_valid=1): stage[0] <= in_data; stage[k] <= stage[k-1] for k = 1..DEPTH-1; the oldest word is dropped.
- in_valid=0: storage holds every bit.
- fill_level update:
  - flush=1: becomes 1 if in_valid=1, otherwise 0.
  - Else if in_valid=1 and fill_level<DEPTH: increments by 1.
  - Else: holds.
  - full is combinational from fill_level.
- Read path, 1-cycle latency:
  - out_data <= stage[tap_addr], sampled from pre-edge storage.
  - out_valid <= (tap_addr < fill_level_pre) && !flush.
  - Pre-edge values are used, so a push in the same cycle is not visible until the next cycle.
- tap_addr ≥ DEPTH (non-power-of-2 DEPTH): out_valid <= 0 and out_data holds its previous value.
- Simultaneous flush and in_valid:
  - The push happens and fill_level becomes 1.
  - out_valid is 0 for that cycle's result.
- At saturation: pushes continue, fill_level stays at DEPTH and full stays 1.
- Reset mid-stream: control state returns to its reset values immediately. Storage keeps stale data, and that data is masked because out_valid = 0 until it is refilled.
- No combinational path from any input to any output except fill_level to full.

Optional Feature:
- Macro: SRL_TAP_INIT_PATTERN_EN.
- Defined: every storage bit has a power-up initial value stage[d][w] = ~((d+w)%2) (checkerboard). This is realised through an initial block / INIT attribute that must be absorbed into the SRL INIT. The fill logic is unchanged, so out_valid still masks the initial contents.
- Undefined: no initial values; storage powers up as X in simulation.

Decomposition:
- Package srl_tap_pkg:
  - function init_bit(d, w) returning the checkerboard value.
  - localparam helper for AW.
  - typedef for the fill_level width.
- Sub-module srl_tap_column: one WIDTH-bit, DEPTH-deep shift column with an enable and an addressed read. This is the SRL-mappable core with no reset.
- The top level adds the fill counter, flush logic and output registers.

Test Plan:
- Reset, then push 0x01..0x05 on consecutive cycles with tap_addr=0. Each next cycle out_data equals the previous push and out_valid=1 after the first push; fill_level ends at 5.
- After 5 pushes, tap_addr=4 gives out_data=0x01 and out_valid=1. tap_addr=5 gives out_valid=0.
- Push 40 words 0x00..0x27 with DEPTH=32. fill_level=32, full=1; tap_addr=31 gives 0x08 and tap_addr=0 gives 0x27.
- flush=1 together with in_valid=1 and in_data=0xAA. Next cycle fill_level=1 and out_valid=0; then tap_addr=0 gives 0xAA with out_valid=1.
- Assert rst_n=0 mid-stream, asynchronously between edges. Outputs are 0 immediately. After release with no pushes, tap_addr=3 keeps out_valid=0.
- Synthesis check with DEPTH=130, WIDTH=130: zero FD* cells in the storage path; the only flops are the control and output registers.

Source files
------------

// File: rtl/srl_tap_pkg.sv
// -----------------------------------------------------------------------------
// srl_tap_pkg
// Shared helpers for the SRL tap reader:
//   tap_aw()       - tap address width derived from the storage depth
//   init_bit()     - checkerboard power-up value for a storage bit
//   fill_level_t   - fill counter type for the default 32-deep configuration
// Optional build macro used by the storage column: SRL_TAP_INIT_PATTERN_EN
// -----------------------------------------------------------------------------
package srl_tap_pkg;

   // Address width for a DEPTH-deep column; depth is always >= 2.
   function automatic int tap_aw(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   // Checkerboard pattern: bit w of stage d powers up as ~((d + w) % 2).
   function automatic logic init_bit(input int d, input int w);
      return (((d + w) % 2) == 0) ? 1'b1 : 1'b0;
   endfunction

   localparam int DEFAULT_DEPTH = 32;
   localparam int DEFAULT_FILL_W = tap_aw(DEFAULT_DEPTH) + 1;

   // One extra bit so the counter can represent DEPTH itself.
   typedef logic [DEFAULT_FILL_W-1:0] fill_level_t;

endpackage

// File: rtl/srl_tap_column.sv
// -----------------------------------------------------------------------------
// srl_tap_column
// WIDTH-bit, DEPTH-deep enable-gated shift column with an addressed
// (combinational) read. No reset on the storage so it maps onto SRL primitives.
// Ports:
//   clk   - clock
//   en    - shift enable; din enters stage 0 and every stage moves down one
//   din   - word shifted into stage 0
//   addr  - stage to read (0 = newest)
//   dout  - contents of stage[addr] (combinational)
// Build macro: SRL_TAP_INIT_PATTERN_EN gives the storage a checkerboard
// power-up value; otherwise the storage starts unknown.
// -----------------------------------------------------------------------------
module srl_tap_column
   import srl_tap_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32,
   parameter int AW    = tap_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   input  logic [AW-1:0]    addr,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

`ifdef SRL_TAP_INIT_PATTERN_EN
   // Power-up contents only; absorbed into the SRL INIT value.
   initial begin
      for (int d = 0; d < DEPTH; d++) begin
         for (int w = 0; w < WIDTH; w++) begin
            stage_q[d][w] = init_bit(d, w);
         end
      end
   end
`endif

   always_comb begin
      stage_d[0] = din;
      for (int k = 1; k < DEPTH; k++) begin
         stage_d[k] = stage_q[k-1];
      end
   end

   // Deliberately no reset: any reset term would block SRL inference.
   always_ff @(posedge clk) begin
      if (en) begin
         stage_q <= stage_d;
      end
   end

   // Out-of-range addresses (non-power-of-2 DEPTH) are masked by the caller.
   assign dout = stage_q[addr];

endmodule

// File: rtl/srl_tap_reader.sv
// -----------------------------------------------------------------------------
// srl_tap_reader
// Enable-gated shift-register delay line with a dynamically addressed read
// tap, a saturating fill counter and a registered output.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset (control/output regs only)
//   in_valid   - push enable
//   in_data    - word pushed into stage 0
//   flush      - synchronous clear of the fill count (storage untouched)
//   tap_addr   - stage to read, 0 = newest
//   out_data   - registered tap data
//   out_valid  - registered; tapped stage holds a word pushed since reset/flush
//   fill_level - pushes since reset/flush, saturating at DEPTH
//   full       - fill_level == DEPTH
// Build macro: SRL_TAP_INIT_PATTERN_EN (storage power-up pattern, see column).
// -----------------------------------------------------------------------------
module srl_tap_reader
   import srl_tap_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32,
   parameter int AW    = tap_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   input  logic [AW-1:0]    tap_addr,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic [AW:0]      fill_level,
   output logic             full
);

   typedef logic [AW:0] fill_t;
   localparam fill_t FILL_MAX = fill_t'(DEPTH);

   logic [WIDTH-1:0] tap_data;
   logic             tap_in_range;

   fill_t            fill_q, fill_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;

   srl_tap_column #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_column (
      .clk  (clk),
      .en   (in_valid),
      .din  (in_data),
      .addr (tap_addr),
      .dout (tap_data)
   );

   // With a power-of-2 depth every address is a real stage.
   generate
      if ((1 << AW) == DEPTH) begin : g_pow2
         assign tap_in_range = 1'b1;
      end else begin : g_npow2
         assign tap_in_range = ({1'b0, tap_addr} < FILL_MAX);
      end
   endgenerate

   always_comb begin
      fill_d      = fill_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;

      if (flush) begin
         fill_d = in_valid ? fill_t'(1) : fill_t'(0);
      end else if (in_valid && (fill_q < FILL_MAX)) begin
         fill_d = fill_q + fill_t'(1);
      end

      // Pre-edge storage and pre-edge fill count: a same-cycle push is not
      // visible until the following cycle.
      if (tap_in_range) begin
         out_data_d  = tap_data;
         out_valid_d = ({1'b0, tap_addr} < fill_q) && !flush;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         fill_q      <= fill_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign fill_level = fill_q;
   assign full       = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_srl_tap_reader.sv
module tb_srl_tap_reader;
   import srl_tap_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             flush;
   logic [AW-1:0]    tap_addr;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic [AW:0]      fill_level;
   logic             full;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   srl_tap_reader #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .flush      (flush),
      .tap_addr   (tap_addr),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .fill_level (fill_level),
      .full       (full)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
         $display("check %-14s observed=%0h expected=%0h ok", tag, obs, exp);
      end else begin
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      flush    = 1'b0;
      tap_addr = '0;
      tick();
      tick();
      check("rst_out_data", 32'(out_data), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_fill", 32'(fill_level), 32'h0);
      check("rst_full", 32'(full), 32'h0);
      #2 rst_n = 1'b1;

      // Push 0x01..0x05 with tap 0; output lags the push by one cycle.
      for (int i = 1; i <= 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i);
         tick();
         if (i == 1) begin
            check("push1_valid", 32'(out_valid), 32'h0);
         end else begin
            check("push_data", 32'(out_data), 32'(i - 1));
            check("push_valid", 32'(out_valid), 32'h1);
         end
      end
      in_valid = 1'b0;
      tick();
      check("last_data", 32'(out_data), 32'h05);
      check("last_valid", 32'(out_valid), 32'h1);
      check("fill_5", 32'(fill_level), 32'd5);
      check("full_5", 32'(full), 32'h0);

      tap_addr = 5'd4;
      tick();
      check("tap4_data", 32'(out_data), 32'h01);
      check("tap4_valid", 32'(out_valid), 32'h1);
      tap_addr = 5'd5;
      tick();
      check("tap5_valid", 32'(out_valid), 32'h0);

      // 40 pushes 0x00..0x27 on top of the 5 already stored.
      tap_addr = 5'd0;
      for (int i = 0; i < 40; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i);
         tick();
         if (i == 25) begin
            check("fill_31", 32'(fill_level), 32'd31);
            check("full_31", 32'(full), 32'h0);
         end
      end
      in_valid = 1'b0;
      tick();
      check("fill_sat", 32'(fill_level), 32'd32);
      check("full_sat", 32'(full), 32'h1);
      tap_addr = 5'd31;
      tick();
      check("tap31_data", 32'(out_data), 32'h08);
      check("tap31_valid", 32'(out_valid), 32'h1);
      tap_addr = 5'd0;
      tick();
      check("tap0_data", 32'(out_data), 32'h27);

      // Flush together with a push.
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      tick();
      check("flpush_fill", 32'(fill_level), 32'd1);
      check("flpush_valid", 32'(out_valid), 32'h0);
      check("flpush_data", 32'(out_data), 32'h27);
      check("flpush_full", 32'(full), 32'h0);
      flush    = 1'b0;
      in_valid = 1'b0;
      tick();
      check("aa_data", 32'(out_data), 32'hAA);
      check("aa_valid", 32'(out_valid), 32'h1);
      tap_addr = 5'd1;
      tick();
      check("stale_valid", 32'(out_valid), 32'h0);
      check("stale_data", 32'(out_data), 32'h27);

      // Flush without a push clears the count.
      flush    = 1'b1;
      tap_addr = 5'd0;
      tick();
      check("flush_fill", 32'(fill_level), 32'd0);
      check("flush_valid", 32'(out_valid), 32'h0);
      flush = 1'b0;
      tick();
      check("postfl_valid", 32'(out_valid), 32'h0);

      // Mid-stream asynchronous reset.
      in_valid = 1'b1;
      in_data  = 8'h55;
      tick();
      tick();
      tick();
      tick();
      check("pre_rst_fill", 32'(fill_level), 32'd4);
      check("pre_rst_data", 32'(out_data), 32'h55);
      #2 rst_n = 1'b0;
      #1;
      check("arst_data", 32'(out_data), 32'h0);
      check("arst_valid", 32'(out_valid), 32'h0);
      check("arst_fill", 32'(fill_level), 32'h0);
      in_valid = 1'b0;
      tap_addr = 5'd3;
      tick();
      #2 rst_n = 1'b1;
      tick();
      check("rel_valid1", 32'(out_valid), 32'h0);
      tick();
      check("rel_valid2", 32'(out_valid), 32'h0);
      check("rel_fill", 32'(fill_level), 32'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
